// File: rtl/hall_pkg.sv
// Shared Hall-sensor code definitions, FSM encoding and sequence helpers.
package hall_pkg;

    localparam int unsigned CODE_W = 3;

    // Valid codes, listed in forward rotation order
    localparam logic [CODE_W-1:0] HALL_101 = 3'b101;
    localparam logic [CODE_W-1:0] HALL_100 = 3'b100;
    localparam logic [CODE_W-1:0] HALL_110 = 3'b110;
    localparam logic [CODE_W-1:0] HALL_010 = 3'b010;
    localparam logic [CODE_W-1:0] HALL_011 = 3'b011;
    localparam logic [CODE_W-1:0] HALL_001 = 3'b001;

    // Codes a healthy sensor set can never produce
    localparam logic [CODE_W-1:0] HALL_000 = 3'b000;
    localparam logic [CODE_W-1:0] HALL_111 = 3'b111;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } hall_state_e;

    // True for the six codes that belong to the rotation sequence
    function automatic logic hall_valid(input logic [CODE_W-1:0] code);
        return (code != HALL_000) && (code != HALL_111);
    endfunction

    // Forward neighbour; illegal codes map to 000 so they never match a valid code
    function automatic logic [CODE_W-1:0] hall_next(input logic [CODE_W-1:0] code);
        case (code)
            HALL_101: return HALL_100;
            HALL_100: return HALL_110;
            HALL_110: return HALL_010;
            HALL_010: return HALL_011;
            HALL_011: return HALL_001;
            HALL_001: return HALL_101;
            default:  return HALL_000;
        endcase
    endfunction

    // Reverse neighbour; illegal codes map to 000 so they never match a valid code
    function automatic logic [CODE_W-1:0] hall_prev(input logic [CODE_W-1:0] code);
        case (code)
            HALL_101: return HALL_001;
            HALL_100: return HALL_101;
            HALL_110: return HALL_100;
            HALL_010: return HALL_110;
            HALL_011: return HALL_010;
            HALL_001: return HALL_011;
            default:  return HALL_000;
        endcase
    endfunction

endpackage

// File: rtl/hall_sync_filter.sv
// Two-flop synchroniser on the three Hall lines followed by a debounce counter.
module hall_sync_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] hall_in,
    output logic              stable_c,
    output logic [CODE_W-1:0] candidate
);

    localparam int unsigned     CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

    logic [CODE_W-1:0] sync1_q;
    logic [CODE_W-1:0] sync2_q;
    logic [CNT_W-1:0]  cnt_q;

    // Metastability guard for the asynchronous sensor inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= hall_in;
            sync2_q <= sync1_q;
        end
    end

    // Any change restarts the count; the count saturates once the code has settled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            candidate <= '0;
            cnt_q     <= '0;
        end else if (sync2_q != candidate) begin
            candidate <= sync2_q;
            cnt_q     <= '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stable_c = (sync2_q == candidate) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/hall_conditioner.sv
// Hall sensor conditioner: filtered code, direction, edge strobe, fault and stall.
module hall_conditioner
    import hall_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 16,
    parameter int unsigned STALL_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic hall_a_in,
    input  logic hall_b_in,
    input  logic hall_c_in,
    output logic HallA,
    output logic HallB,
    output logic HallC,
    output logic edge_pulse,
    output logic dir,
    output logic hall_fault,
    output logic stall
);

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic              stable_c;
    logic [CODE_W-1:0] candidate;

    hall_state_e       state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              pulse_q, pulse_d;
    logic              dir_q, dir_d;
    logic              fault_q, fault_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              stall_q, stall_d;

    hall_sync_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .hall_in   ({hall_a_in, hall_b_in, hall_c_in}),
        .stable_c  (stable_c),
        .candidate (candidate)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            code_q      <= HALL_000;
            pulse_q     <= 1'b0;
            dir_q       <= 1'b1;
            fault_q     <= 1'b0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            pulse_q     <= pulse_d;
            dir_q       <= dir_d;
            fault_q     <= fault_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    // Act only on a settled code that differs from the one currently presented
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        pulse_d     = 1'b0;
        dir_d       = dir_q;
        fault_d     = fault_q;
        stall_cnt_d = stall_cnt_q;
        stall_d     = (stall_cnt_q == STALL_MAX);

        if (stable_c && (candidate != code_q)) begin
            case (state_q)
                ST_INIT: begin
                    if (hall_valid(candidate)) begin
                        code_d  = candidate;
                        state_d = ST_RUN;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                ST_RUN: begin
                    if (!hall_valid(candidate)) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        code_d  = candidate;
                        pulse_d = 1'b1;
                        if (candidate == hall_next(code_q)) begin
                            dir_d = 1'b1;
                        end else if (candidate == hall_prev(code_q)) begin
                            dir_d = 1'b0;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    if (hall_valid(candidate)) begin
                        code_d  = candidate;
                        pulse_d = 1'b1;
                        if (candidate == hall_next(code_q)) begin
                            dir_d   = 1'b1;
                            fault_d = 1'b0;
                            state_d = ST_RUN;
                        end else if (candidate == hall_prev(code_q)) begin
                            dir_d   = 1'b0;
                            fault_d = 1'b0;
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end

        // Edge clears the stall timer; otherwise it counts outside INIT and saturates
        if (pulse_d) begin
            stall_cnt_d = '0;
        end else if ((state_q != ST_INIT) && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    assign {HallA, HallB, HallC} = code_q;
    assign edge_pulse            = pulse_q;
    assign dir                   = dir_q;
    assign hall_fault            = fault_q;
    assign stall                 = stall_q;

endmodule

// File: tb/tb_hall_conditioner.sv
// Self-checking bench for hall_conditioner with a behavioural reference model.
module tb_hall_conditioner;

    localparam int FILT = 16;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hall_a_in = 1'b0;
    logic hall_b_in = 1'b0;
    logic hall_c_in = 1'b0;
    logic HallA, HallB, HallC, edge_pulse, dir, hall_fault, stall;

    always #5 clk = ~clk;

    hall_conditioner #(
        .FILT_CYCLES (FILT),
        .STALL_W     (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hall_a_in  (hall_a_in),
        .hall_b_in  (hall_b_in),
        .hall_c_in  (hall_c_in),
        .HallA      (HallA),
        .HallB      (HallB),
        .HallC      (HallC),
        .edge_pulse (edge_pulse),
        .dir        (dir),
        .hall_fault (hall_fault),
        .stall      (stall)
    );

    int n_vec = 0;
    int n_err = 0;

    // Forward rotation order
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    // Reference model state
    logic [2:0] h1, h2, run_code, m_code;
    int         run;
    int         m_state;   // 0 = init, 1 = run, 2 = fault
    logic       m_pulse, m_dir, m_fault, m_stall;
    int         m_cnt;
    int         seg_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [2:0] fwd_of(input logic [2:0] c);
        int i = idx_of(c);
        if (i < 0) return 3'b000;
        return seq[(i + 1) % 6];
    endfunction

    function automatic logic [2:0] rev_of(input logic [2:0] c);
        int i = idx_of(c);
        if (i < 0) return 3'b000;
        return seq[(i + 5) % 6];
    endfunction

    task automatic model_reset();
        h1 = 3'b000; h2 = 3'b000; run_code = 3'b000; run = 1;
        m_state = 0; m_code = 3'b000; m_pulse = 1'b0; m_dir = 1'b1;
        m_fault = 1'b0; m_stall = 1'b0; m_cnt = 0;
    endtask

    // One clock edge of the reference: 2-sample input delay, run-length debounce, rules
    task automatic model_edge();
        logic [2:0] raw, old;
        int st_before;
        if (!rst) begin
            model_reset();
            return;
        end
        raw = h2; h2 = h1; h1 = {hall_a_in, hall_b_in, hall_c_in};
        if (raw == run_code) begin
            if (run < 100000) run++;
        end else begin
            run_code = raw;
            run = 1;
        end
        m_stall   = (m_cnt == SMAX);
        st_before = m_state;
        m_pulse   = 1'b0;
        if (run > FILT && raw != m_code) begin
            old = m_code;
            if (m_state == 0) begin
                if (idx_of(raw) >= 0) begin m_code = raw; m_state = 1; end
                else begin m_fault = 1'b1; m_state = 2; end
            end else if (m_state == 1) begin
                if (idx_of(raw) < 0) begin
                    m_fault = 1'b1; m_state = 2;
                end else begin
                    m_code = raw; m_pulse = 1'b1;
                    if (raw == fwd_of(old)) m_dir = 1'b1;
                    else if (raw == rev_of(old)) m_dir = 1'b0;
                    else begin m_fault = 1'b1; m_state = 2; end
                end
            end else begin
                if (idx_of(raw) >= 0) begin
                    m_code = raw; m_pulse = 1'b1;
                    if (raw == fwd_of(old)) begin m_dir = 1'b1; m_fault = 1'b0; m_state = 1; end
                    else if (raw == rev_of(old)) begin m_dir = 1'b0; m_fault = 1'b0; m_state = 1; end
                end
            end
        end
        if (m_pulse) m_cnt = 0;
        else if (st_before != 0 && m_cnt < SMAX) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("hall", 32'({HallA, HallB, HallC}), 32'(m_code));
        check("edge_pulse", 32'(edge_pulse), 32'(m_pulse));
        check("dir", 32'(dir), 32'(m_dir));
        check("hall_fault", 32'(hall_fault), 32'(m_fault));
        check("stall", 32'(stall), 32'(m_stall));
    endtask

    task automatic set_in(input logic [2:0] c);
        {hall_a_in, hall_b_in, hall_c_in} = c;
    endtask

    task automatic hold(input logic [2:0] c, input int n);
        set_in(c);
        seg_pulses = 0;
        repeat (n) begin
            tick();
            if (edge_pulse) seg_pulses++;
        end
    endtask

    task automatic wait_pulse(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!edge_pulse && k < 60);
        check(tag, 32'(edge_pulse), 32'd1);
    endtask

    initial begin
        int p;
        logic [2:0] cur, nc;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_hall", 32'({HallA, HallB, HallC}), 32'd0);
        check("rst_dir", 32'(dir), 32'd1);

        // First acceptance from INIT lands on clock FILT+3
        rst = 1'b1;
        set_in(3'b101);
        repeat (FILT + 2) tick();
        check("init_before", 32'({HallA, HallB, HallC}), 32'd0);
        tick();
        check("init_accept", 32'({HallA, HallB, HallC}), 32'b101);
        check("init_no_pulse", 32'(edge_pulse), 32'd0);
        check("init_dir", 32'(dir), 32'd1);
        check("init_fault", 32'(hall_fault), 32'd0);
        hold(3'b101, 21);

        // Forward steps then one reverse step
        hold(3'b100, 40);
        check("fwd1_pulses", 32'(seg_pulses), 32'd1);
        check("fwd1_dir", 32'(dir), 32'd1);
        hold(3'b110, 40);
        check("fwd2_pulses", 32'(seg_pulses), 32'd1);
        check("fwd2_dir", 32'(dir), 32'd1);
        hold(3'b100, 40);
        check("rev_pulses", 32'(seg_pulses), 32'd1);
        check("rev_dir", 32'(dir), 32'd0);
        hold(3'b101, 40);

        // Glitch rejection and a settled change
        hold(3'b001, 10); p = seg_pulses;
        hold(3'b101, 40); p += seg_pulses;
        check("glitch10_pulses", 32'(p), 32'd0);
        check("glitch10_hall", 32'({HallA, HallB, HallC}), 32'b101);
        hold(3'b001, 15); p = seg_pulses;
        hold(3'b101, 40); p += seg_pulses;
        check("glitch15_pulses", 32'(p), 32'd0);
        check("glitch15_hall", 32'({HallA, HallB, HallC}), 32'b101);
        hold(3'b001, 40);
        check("settle_pulses", 32'(seg_pulses), 32'd1);
        check("settle_hall", 32'({HallA, HallB, HallC}), 32'b001);

        // Illegal code in RUN, then recovery via the adjacent code
        hold(3'b111, 30);
        check("ill_fault", 32'(hall_fault), 32'd1);
        check("ill_hold", 32'({HallA, HallB, HallC}), 32'b001);
        set_in(3'b101);
        wait_pulse("recover_pulse");
        check("recover_fault", 32'(hall_fault), 32'd0);
        check("recover_dir", 32'(dir), 32'd1);

        // Stall saturation and release
        repeat (SMAX) tick();
        check("stall_before", 32'(stall), 32'd0);
        tick();
        check("stall_set", 32'(stall), 32'd1);
        repeat (10) tick();
        set_in(3'b100);
        wait_pulse("unstall_pulse");
        check("stall_at_pulse", 32'(stall), 32'd1);
        tick();
        check("stall_clear", 32'(stall), 32'd0);

        // Asynchronous reset while the filter is mid-count
        set_in(3'b010);
        repeat (12) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_hall", 32'({HallA, HallB, HallC}), 32'd0);
        check("arst_pulse", 32'(edge_pulse), 32'd0);
        check("arst_dir", 32'(dir), 32'd1);
        check("arst_fault", 32'(hall_fault), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        hold(3'b010, FILT + 2);
        check("reinit_before", 32'({HallA, HallB, HallC}), 32'd0);
        hold(3'b010, 1);
        check("reinit_accept", 32'({HallA, HallB, HallC}), 32'b010);
        check("reinit_no_pulse", 32'(edge_pulse), 32'd0);
        hold(3'b010, 20);

        // Randomised walk: neighbours, skips, illegal codes and short glitches
        cur = 3'b010;
        for (int s = 0; s < 300; s++) begin
            int r = int'($urandom_range(0, 9));
            if (idx_of(cur) < 0 || r == 8) nc = seq[$urandom_range(0, 5)];
            else if (r <= 5) nc = fwd_of(cur);
            else if (r <= 7) nc = rev_of(cur);
            else nc = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
            hold(nc, int'($urandom_range(1, 45)));
            cur = nc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
